// File: rtl/mips_instr_encoder_loader_if.sv
// Command bus (host -> loader) and IM write bus (loader -> IM) of the encoder/loader.
interface mips_instr_encoder_loader_if #(
  parameter int ADDR_W = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [4:0]        cmd_rs;
  logic [4:0]        cmd_rt;
  logic [4:0]        cmd_rd;
  logic [15:0]       cmd_imm;
  logic [25:0]       cmd_tgt;
  logic              cmd_last;
  logic              im_we;
  logic              im_ready;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  // Host side: issues commands and plays the IM write target
  modport master (
    output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_tgt, cmd_last, im_ready,
    input  cmd_ready, im_we, im_addr, im_wdata
  );

  // Loader side: accepts commands and drives IM writes
  modport slave (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_tgt, cmd_last, im_ready,
    output cmd_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/mips_instr_encoder_loader.sv
// Encodes field-level MIPS commands into 32-bit words and streams them into
// instruction memory through a small FIFO with backpressure.
module mips_instr_encoder_loader #(
  parameter int ADDR_W = 10,
  parameter int FIFO_D = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  mips_instr_encoder_loader_if.slave bus,
  output logic                      busy,
  output logic                      done,
  output logic                      err_illegal,
  output logic                      err_full,
  output logic [ADDR_W:0]           word_count
);
  localparam int              PTR_W     = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam logic [PTR_W:0]  FULL_CNT  = (PTR_W+1)'(FIFO_D);
  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [31:0]       fifo_mem [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic [ADDR_W-1:0] addr;
  // Words committed to the FIFO this session; bounds the session to DEPTH words
  logic [ADDR_W:0]   push_cnt;

  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        legal;
  logic        room;
  logic        push;
  logic        pop;
  logic [31:0] enc_word;

  function automatic logic [31:0] encode(input logic [3:0]  op,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [15:0] imm,
                                         input logic [25:0] tgt);
    logic [31:0] w;
    w = '0;
    case (op)
      4'd1:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100001};
      4'd2:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100011};
      4'd3:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
      4'd4:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
      4'd5:    w = {6'b001101, rs, rt, imm};
      4'd6:    w = {6'b001111, 5'd0, rt, imm};
      4'd7:    w = {6'b100011, rs, rt, imm};
      4'd8:    w = {6'b101011, rs, rt, imm};
      4'd9:    w = {6'b000100, rs, rt, imm};
      4'd10:   w = {6'b000011, tgt};
      4'd11:   w = {6'b000000, rs, 15'd0, 6'b001000};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);

  assign bus.cmd_ready = (state == S_RUN) && !fifo_full;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign legal         = (bus.cmd_op <= 4'd11);
  assign room          = (push_cnt != DEPTH);
  assign push          = accept && legal && room;
  assign pop           = bus.im_we && bus.im_ready;

  assign enc_word = encode(bus.cmd_op, bus.cmd_rs, bus.cmd_rt, bus.cmd_rd,
                           bus.cmd_imm, bus.cmd_tgt);

  // Head of the FIFO is presented directly; zero when nothing is buffered
  assign bus.im_we    = !fifo_empty;
  assign bus.im_wdata = fifo_empty ? 32'd0 : fifo_mem[rd_ptr];
  assign bus.im_addr  = addr;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Session FSM with address/word counters and sticky error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      addr        <= '0;
      word_count  <= '0;
      push_cnt    <= '0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RUN;
            addr        <= '0;
            word_count  <= '0;
            push_cnt    <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
          end
        end
        S_RUN:   if (accept && bus.cmd_last) state <= S_DRAIN;
        S_DRAIN: if (fifo_empty) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (accept && !legal)        err_illegal <= 1'b1;
      if (accept && legal && !room) err_full   <= 1'b1;
      if (push) push_cnt <= push_cnt + 1'b1;
      if (pop) begin
        word_count <= word_count + 1'b1;
        // Hold at the top word instead of wrapping back onto address 0
        if (addr != LAST_ADDR) addr <= addr + 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; entries are only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end
endmodule
